// File: rtl/vga_scan_gen.sv
// vga_scan_gen: VGA timing generator and scan-out pipeline.
// A clock-enable divider produces the pixel rate. Stage 0 holds the h/v
// counters. Stage 1 registers the memory address, read enable, sync and
// blank. Stage 2 registers the returned pixel together with sync and blank,
// so everything reaches the pins on the same edge.
// Optional feature: define VGA_SCAN_TESTPAT_EN to enable the XOR test
// pattern selected by test_mode.
module vga_scan_gen #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int PIX_DIV     = 4,
    parameter int SCALE_SHIFT = 2,
    parameter int ADDR        = 16,
    parameter int DATA        = 8
) (
    input  logic            clk,
    input  logic            rst_L,
    output logic [ADDR-1:0] vram_addr,
    output logic            vram_re,
    input  logic [DATA-1:0] vram_data,
    input  logic            test_mode,
    output logic [DATA-1:0] rgb,
    output logic            hsync,
    output logic            vsync,
    output logic            blank,
    output logic            frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int DVW     = $clog2(PIX_DIV);
    localparam int FB_W    = H_ACTIVE >> SCALE_SHIFT;

    localparam logic [DVW-1:0] DIV_LAST   = DVW'(PIX_DIV - 1);
    localparam logic [HW-1:0]  H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0]  H_ACT      = HW'(H_ACTIVE);
    localparam logic [HW-1:0]  H_SYNC_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0]  H_SYNC_END = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0]  V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0]  V_ACT      = VW'(V_ACTIVE);
    localparam logic [VW-1:0]  V_SYNC_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0]  V_SYNC_END = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [DVW-1:0]  r_div;
    logic [HW-1:0]   r_hcount;
    logic [VW-1:0]   r_vcount;
    logic [ADDR-1:0] r_vram_addr;
    logic            r_vram_re;
    logic            r_hs1;
    logic            r_vs1;
    logic            r_blank1;
    logic            r_first1;
    logic [DATA-1:0] r_rgb;
    logic            r_hsync;
    logic            r_vsync;
    logic            r_blank;
    logic            r_frame_start;

    logic            w_pix_en;
    logic            w_active;
    logic            w_hs;
    logic            w_vs;
    logic            w_first;
    logic [ADDR-1:0] w_addr;
    logic [DATA-1:0] w_pixel;

    assign w_pix_en = (r_div == DIV_LAST);
    assign w_active = (r_hcount < H_ACT) && (r_vcount < V_ACT);
    assign w_hs     = !((r_hcount >= H_SYNC_BEG) && (r_hcount <= H_SYNC_END));
    assign w_vs     = !((r_vcount >= V_SYNC_BEG) && (r_vcount <= V_SYNC_END));
    assign w_first  = (r_hcount == '0) && (r_vcount == '0);
    // Each framebuffer texel is replicated 2^SCALE_SHIFT times in both axes.
    assign w_addr   = ADDR'((32'(r_vcount) >> SCALE_SHIFT) * FB_W
                          + (32'(r_hcount) >> SCALE_SHIFT));

`ifdef VGA_SCAN_TESTPAT_EN
    logic [HW-1:0] r_hcount1;
    logic [VW-1:0] r_vcount1;

    // Stage-1 copies of the counters, aligned with the address in flight.
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            r_hcount1 <= '0;
            r_vcount1 <= '0;
        end else if (w_pix_en) begin
            r_hcount1 <= r_hcount;
            r_vcount1 <= r_vcount;
        end
    end

    assign w_pixel = test_mode ? DATA'(8'(r_hcount1) ^ 8'(r_vcount1)) : vram_data;
`else
    logic w_unused_test_mode;
    assign w_unused_test_mode = test_mode;
    assign w_pixel = vram_data;
`endif

    // Pixel clock-enable divider.
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L)        r_div <= '0;
        else if (w_pix_en) r_div <= '0;
        else               r_div <= r_div + 1'b1;
    end

    // Stage 0: horizontal and vertical position counters.
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            r_hcount <= '0;
            r_vcount <= '0;
        end else if (w_pix_en) begin
            if (r_hcount == H_LAST) begin
                r_hcount <= '0;
                if (r_vcount == V_LAST) r_vcount <= '0;
                else                    r_vcount <= r_vcount + 1'b1;
            end else begin
                r_hcount <= r_hcount + 1'b1;
            end
        end
    end

    // Stage 1: memory request plus timing flags for the same position.
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            r_vram_addr <= '0;
            r_vram_re   <= 1'b0;
            r_hs1       <= 1'b1;
            r_vs1       <= 1'b1;
            r_blank1    <= 1'b1;
            r_first1    <= 1'b0;
        end else if (w_pix_en) begin
            r_vram_addr <= w_active ? w_addr : '0;
            r_vram_re   <= w_active;
            r_hs1       <= w_hs;
            r_vs1       <= w_vs;
            r_blank1    <= !w_active;
            r_first1    <= w_first;
        end
    end

    // Stage 2: capture pixel data (address has been stable a full pixel) and
    // delay sync/blank by the same amount. Data is ignored while blanked.
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            r_rgb   <= '0;
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
            r_blank <= 1'b1;
        end else if (w_pix_en) begin
            r_rgb   <= r_blank1 ? '0 : w_pixel;
            r_hsync <= r_hs1;
            r_vsync <= r_vs1;
            r_blank <= r_blank1;
        end
    end

    // One-clk pulse in the cycle pixel (0,0) first appears on the pins.
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) r_frame_start <= 1'b0;
        else        r_frame_start <= w_pix_en && r_first1;
    end

    assign vram_addr   = r_vram_addr;
    assign vram_re     = r_vram_re;
    assign rgb         = r_rgb;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign blank       = r_blank;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_scan_gen.sv
// tb_vga_scan_gen: checks vga_scan_gen every clock against a position-based
// reference model, using a reduced timing so several frames fit in the run.
module tb_vga_scan_gen;

    localparam int HA  = 16, HFP = 2, HS = 3, HBP = 3;
    localparam int VA  = 8,  VFP = 1, VS = 2, VBP = 2;
    localparam int PD  = 4,  SS  = 1, AW = 16, DW = 8;
    localparam int HT  = HA + HFP + HS + HBP;
    localparam int VT  = VA + VFP + VS + VBP;
    localparam int FRAME = HT * VT * PD;

    logic          clk = 1'b0;
    logic          rst_L;
    logic          test_mode;
    logic [AW-1:0] vram_addr;
    logic          vram_re;
    logic [DW-1:0] vram_data;
    logic [DW-1:0] rgb;
    logic          hsync;
    logic          vsync;
    logic          blank;
    logic          frame_start;

    logic [7:0] mem [256];
    int n_chk  = 0;
    int n_err  = 0;
    int n_edge = 0;
    int fs_cnt;
    int first_fs;
    int k_run;

    always #5 clk = ~clk;

    // Memory returns 0xFF whenever no read is requested, so any use of
    // unrequested data shows up on rgb.
    assign vram_data = vram_re ? mem[vram_addr[7:0]] : 8'hFF;

    vga_scan_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .PIX_DIV(PD), .SCALE_SHIFT(SS), .ADDR(AW), .DATA(DW)
    ) dut (
        .clk        (clk),
        .rst_L      (rst_L),
        .vram_addr  (vram_addr),
        .vram_re    (vram_re),
        .vram_data  (vram_data),
        .test_mode  (test_mode),
        .rgb        (rgb),
        .hsync      (hsync),
        .vsync      (vsync),
        .blank      (blank),
        .frame_start(frame_start)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d at t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int fb_addr(input int h, input int v);
        return (v >> SS) * (HA >> SS) + (h >> SS);
    endfunction

    function automatic int pixel_model(input int h, input int v);
`ifdef VGA_SCAN_TESTPAT_EN
        if (test_mode) return (h ^ v) & 255;
`endif
        return int'(mem[fb_addr(h, v) & 255]);
    endfunction

    // Expected pins derived from how many pixel ticks have elapsed since
    // reset release: the request shows position tick-1, the pins tick-2.
    task automatic check_all();
        int p, q, h, v;
        int e_re, e_addr, e_rgb, e_hs, e_vs, e_bl, e_fs;
        p = n_edge / PD;
        e_re = 0; e_addr = 0; e_rgb = 0; e_hs = 1; e_vs = 1; e_bl = 1; e_fs = 0;
        if (p >= 1) begin
            q = p - 1;
            h = q % HT;
            v = (q / HT) % VT;
            if (h < HA && v < VA) begin
                e_re   = 1;
                e_addr = fb_addr(h, v);
            end
        end
        if (p >= 2) begin
            q = p - 2;
            h = q % HT;
            v = (q / HT) % VT;
            e_bl = (h < HA && v < VA) ? 0 : 1;
            e_hs = (h >= HA + HFP && h < HA + HFP + HS) ? 0 : 1;
            e_vs = (v >= VA + VFP && v < VA + VFP + VS) ? 0 : 1;
            if (e_bl == 0) e_rgb = pixel_model(h, v);
            e_fs = (n_edge % PD == 0 && q % (HT * VT) == 0) ? 1 : 0;
        end
        check("vram_re",     int'(vram_re),     e_re);
        check("vram_addr",   int'(vram_addr),   e_addr);
        check("rgb",         int'(rgb),         e_rgb);
        check("hsync",       int'(hsync),       e_hs);
        check("vsync",       int'(vsync),       e_vs);
        check("blank",       int'(blank),       e_bl);
        check("frame_start", int'(frame_start), e_fs);
    endtask

    initial begin
        rst_L     = 1'b1;
        test_mode = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);

        // Asynchronous reset assertion before any clock edge.
        #2 rst_L = 1'b0;
        #1 n_edge = 0;
        check_all();
        repeat (3) begin
            @(posedge clk); #1;
            check_all();
        end

        // Release away from the edge and run three frames.
        #4 rst_L = 1'b1;
        fs_cnt = 0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            @(posedge clk); #1;
            n_edge++;
            check_all();
            if (frame_start) fs_cnt++;
        end
        check("fs_per_3frames", fs_cnt, 3);

        // Continue into the next frame and reset at a random mid-frame point.
        k_run = int'($urandom_range(5 * HT * PD, 6 * HT * PD - 1));
        for (int i = 0; i < k_run; i++) begin
            @(posedge clk); #1;
            n_edge++;
            check_all();
        end
        #2 rst_L = 1'b0;
        #1 n_edge = 0;
        check_all();
        test_mode = 1'($urandom_range(0, 1));
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        repeat (2) begin
            @(posedge clk); #1;
            check_all();
        end

        #4 rst_L = 1'b1;
        fs_cnt   = 0;
        first_fs = -1;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(posedge clk); #1;
            n_edge++;
            check_all();
            if (frame_start) begin
                fs_cnt++;
                if (first_fs < 0) first_fs = n_edge;
            end
        end
        check("fs_first_after_reset", first_fs, 2 * PD);
        check("fs_per_2frames", fs_cnt, 2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
